// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column debounce, key encoding and a FWFT key FIFO.
// Optional auto-repeat while a key is held is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  cols,
    output logic [3:0]                  rows,
    output logic [3:0]                  key_code,
    output logic                        key_valid,
    input  logic                        key_pop,
    output logic [$clog2(FIFO_DEPTH):0] key_count,
    output logic                        overflow
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic [3:0]    cols_meta, cols_sync;
    logic [DW-1:0] div;
    logic [1:0]    row_idx;
    logic          sample, scan_end;
    logic [3:0]    pressed_row0, pressed_row1, pressed_row2;
    logic [15:0]   pressed;
    logic          hit;
    logic [3:0]    code;

    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] rel, rel_n;
    logic [RW-1:0] rpt, rpt_n;
    logic          push_now, push_q;
    logic [3:0]    push_code;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop_ok, push_ok, drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cols_meta <= 4'hF;
            cols_sync <= 4'hF;
        end else begin
            cols_meta <= cols;
            cols_sync <= cols_meta;
        end
    end

    assign sample   = (div == DIV_LAST);
    assign scan_end = sample && (row_idx == 2'd3);
    assign rows     = ~(4'b0001 << row_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div     <= '0;
            row_idx <= 2'd0;
        end else if (sample) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            div     <= div + DW'(1);
        end
    end

    // Rows 0..2 are latched at their sample points; row 3 is read live at scan_end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pressed_row0 <= 4'h0;
            pressed_row1 <= 4'h0;
            pressed_row2 <= 4'h0;
        end else if (sample) begin
            case (row_idx)
                2'd0:    pressed_row0 <= ~cols_sync;
                2'd1:    pressed_row1 <= ~cols_sync;
                2'd2:    pressed_row2 <= ~cols_sync;
                default: ;
            endcase
        end
    end

    assign pressed = {~cols_sync, pressed_row2, pressed_row1, pressed_row0};

    // Bit index is row*4+col, so the lowest set bit is the lowest row, then lowest column.
    always_comb begin
        hit  = 1'b0;
        code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pressed[i]) begin
                hit  = 1'b1;
                code = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            rel       <= '0;
            rpt       <= '0;
            push_q    <= 1'b0;
            push_code <= 4'd0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rel       <= rel_n;
            rpt       <= rpt_n;
            push_q    <= push_now;
            if (push_now) push_code <= code;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rel_n   = rel;
        rpt_n   = rpt;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        cand_n  = code;
                        cnt_n   = CW'(1);
                        rel_n   = '0;
                        rpt_n   = '0;
                        state_n = (DEB_LAST == CW'(1)) ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (hit && (code == cand)) begin
                        cnt_n = cnt + CW'(1);
                        if (cnt_n == DEB_LAST) begin
                            state_n = HELD;
                            rel_n   = '0;
                            rpt_n   = '0;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        rpt_n = '0;
                        rel_n = rel + CW'(1);
                        if (rel_n == DEB_LAST) state_n = IDLE;
                    end else begin
                        rel_n = '0;
                        if (REPEAT_ON && (code == cand))
                            rpt_n = (rpt + RW'(1) == RPT_LAST) ? '0 : rpt + RW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        push_now = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE:     push_now = hit && (DEB_LAST == CW'(1));
                DEBOUNCE: push_now = hit && (code == cand) && (cnt + CW'(1) == DEB_LAST);
                HELD:     push_now = REPEAT_ON && hit && (code == cand) && (rpt + RW'(1) == RPT_LAST);
                default:  push_now = 1'b0;
            endcase
        end
    end

    // Consumer handshake: key_valid means key_code holds the oldest entry; a key_pop
    // cycle with key_valid=1 consumes it on that edge, key_pop with key_valid=0 is ignored.
    assign full      = (count == FULL_CNT);
    assign key_valid = (count != '0);
    assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;
    assign key_count = count;
    assign pop_ok    = key_pop && key_valid;
    assign push_ok   = push_q && (!full || pop_ok);
    assign drop      = push_q && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives cols from rows and pressed keys.
// Build with or without KEYPAD_REPEAT_EN; repeat-dependent expectations follow the macro.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int FD = 4;
    localparam int RS = 2;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pop = 1'b0;
    logic [2:0] key_count;
    logic       overflow;
    logic [15:0] keys = 16'h0;

    int n_vec = 0;
    int n_err = 0;

    keypad_scanner #(
        .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(FD), .REPEAT_SCANS(RS)
    ) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows), .key_code(key_code),
        .key_valid(key_valid), .key_pop(key_pop), .key_count(key_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
    end

    // Hold the key pattern for n full scans; starts and ends one cycle into a scan.
    task automatic scans(input logic [15:0] k, input int n);
        keys = k;
        repeat (16 * n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        logic [3:0] prev;
        bit found;
        prev  = rows;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk); #1;
            if (rows == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = rows;
        end
        n_vec++;
        if (!found) begin
            $display("FAIL align: row 3 -> row 0 wrap not seen within 64 cycles, rows=%b", rows);
            n_err++;
        end
        @(posedge clk); #1;
    endtask

    task automatic pop1();
        key_pop = 1'b1;
        @(posedge clk); #1;
        key_pop = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] exp_rows;
        one = 4'b0001;
        rst = 1'b0;
        keys = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (rows !== 4'b1110) begin $display("FAIL reset_rows: got %b want 1110", rows); n_err++; end
        n_vec++; if (key_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", key_valid); n_err++; end
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL reset_count: got %0d want 0", key_count); n_err++; end
        n_vec++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow: got %b want 0", overflow); n_err++; end
        n_vec++; if (key_code !== 4'd0) begin $display("FAIL reset_code: got %0d want 0", key_code); n_err++; end
        rst = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            exp_rows = ~(one << ((k / 4) % 4));
            n_vec++;
            if (rows !== exp_rows) begin
                $display("FAIL row_cycle[%0d]: got %b want %b", k, rows, exp_rows);
                n_err++;
            end
        end
    endtask

    task automatic test_single_press();
        logic [15:0] k;
        k = 16'h0200;
        align();
        scans(k, 2);
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL single_early: got %0d want 0", key_count); n_err++; end
        scans(k, 1);
        n_vec++; if (key_count !== 3'd1) begin $display("FAIL single_count: got %0d want 1", key_count); n_err++; end
        n_vec++; if (key_valid !== 1'b1) begin $display("FAIL single_valid: got %b want 1", key_valid); n_err++; end
        n_vec++; if (key_code !== 4'd9) begin $display("FAIL single_code: got %0d want 9", key_code); n_err++; end
        scans(k, 2);
        n_vec++; if (key_count !== 3'(1 + REP)) begin $display("FAIL single_hold: got %0d want %0d", key_count, 1 + REP); n_err++; end
        scans(16'h0, 3);
        n_vec++; if (key_count !== 3'(1 + REP)) begin $display("FAIL single_release: got %0d want %0d", key_count, 1 + REP); n_err++; end
        for (int j = 0; j < 1 + REP; j++) begin
            n_vec++; if (key_code !== 4'd9) begin $display("FAIL single_head[%0d]: got %0d want 9", j, key_code); n_err++; end
            pop1();
        end
        n_vec++; if (key_valid !== 1'b0) begin $display("FAIL single_pop_valid: got %b want 0", key_valid); n_err++; end
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL single_pop_count: got %0d want 0", key_count); n_err++; end
        n_vec++; if (key_code !== 4'd0) begin $display("FAIL single_empty_code: got %0d want 0", key_code); n_err++; end
    endtask

    task automatic test_bounce();
        align();
        scans(16'h0001, 2);
        scans(16'h0000, 1);
        scans(16'h0001, 2);
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL bounce_mid: got %0d want 0", key_count); n_err++; end
        scans(16'h0000, 3);
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL bounce_end: got %0d want 0", key_count); n_err++; end
        n_vec++; if (key_valid !== 1'b0) begin $display("FAIL bounce_valid: got %b want 0", key_valid); n_err++; end
    endtask

    task automatic test_two_keys();
        align();
        scans(16'h1080, 4);
        n_vec++; if (key_count !== 3'd1) begin $display("FAIL two_count: got %0d want 1", key_count); n_err++; end
        n_vec++; if (key_code !== 4'd7) begin $display("FAIL two_code: got %0d want 7", key_code); n_err++; end
        scans(16'h0000, 3);
        n_vec++; if (key_count !== 3'd1) begin $display("FAIL two_release: got %0d want 1", key_count); n_err++; end
        pop1();
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL two_pop: got %0d want 0", key_count); n_err++; end
    endtask

    task automatic test_overflow();
        logic [3:0] codes [5];
        logic [15:0] one;
        codes = '{4'd1, 4'd4, 4'd10, 4'd15, 4'd3};
        one = 16'h0001;
        align();
        for (int i = 0; i < 5; i++) begin
            scans(one << codes[i], 3);
            scans(16'h0000, 3);
            if (i == 3) begin
                n_vec++; if (key_count !== 3'd4) begin $display("FAIL ovf_fill: got %0d want 4", key_count); n_err++; end
                n_vec++; if (overflow !== 1'b0) begin $display("FAIL ovf_early: got %b want 0", overflow); n_err++; end
            end
        end
        n_vec++; if (key_count !== 3'd4) begin $display("FAIL ovf_count: got %0d want 4", key_count); n_err++; end
        n_vec++; if (overflow !== 1'b1) begin $display("FAIL ovf_flag: got %b want 1", overflow); n_err++; end
        n_vec++; if (key_code !== 4'd1) begin $display("FAIL ovf_head: got %0d want 1", key_code); n_err++; end
        // Third scan of key 6 runs to its scan_end edge, then pop lands on the push cycle.
        scans(16'h0040, 2);
        repeat (15) @(posedge clk);
        #1;
        pop1();
        n_vec++; if (key_count !== 3'd4) begin $display("FAIL ovf_pushpop_count: got %0d want 4", key_count); n_err++; end
        n_vec++; if (overflow !== 1'b1) begin $display("FAIL ovf_pushpop_flag: got %b want 1", overflow); n_err++; end
        n_vec++; if (key_code !== 4'd4) begin $display("FAIL ovf_pushpop_head: got %0d want 4", key_code); n_err++; end
        scans(16'h0000, 3);
        pop1();
        n_vec++; if (key_code !== 4'd10) begin $display("FAIL ovf_order1: got %0d want 10", key_code); n_err++; end
        pop1();
        n_vec++; if (key_code !== 4'd15) begin $display("FAIL ovf_order2: got %0d want 15", key_code); n_err++; end
        n_vec++; if (key_count !== 3'd2) begin $display("FAIL ovf_drain: got %0d want 2", key_count); n_err++; end
    endtask

    task automatic test_reset_mid();
        align();
        scans(16'h0004, 2);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL rmid_count: got %0d want 0", key_count); n_err++; end
        n_vec++; if (key_valid !== 1'b0) begin $display("FAIL rmid_valid: got %b want 0", key_valid); n_err++; end
        n_vec++; if (overflow !== 1'b0) begin $display("FAIL rmid_overflow: got %b want 0", overflow); n_err++; end
        n_vec++; if (rows !== 4'b1110) begin $display("FAIL rmid_rows: got %b want 1110", rows); n_err++; end
        rst = 1'b1;
        align();
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL rmid_scan1: got %0d want 0", key_count); n_err++; end
        scans(16'h0004, 1);
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL rmid_scan2: got %0d want 0", key_count); n_err++; end
        scans(16'h0004, 1);
        n_vec++; if (key_count !== 3'd1) begin $display("FAIL rmid_scan3: got %0d want 1", key_count); n_err++; end
        n_vec++; if (key_code !== 4'd2) begin $display("FAIL rmid_code: got %0d want 2", key_code); n_err++; end
        scans(16'h0000, 3);
        pop1();
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL rmid_pop: got %0d want 0", key_count); n_err++; end
    endtask

    task automatic test_repeat();
        align();
        scans(16'h0020, 8);
        n_vec++; if (key_count !== 3'(1 + 2 * REP)) begin $display("FAIL repeat_count: got %0d want %0d", key_count, 1 + 2 * REP); n_err++; end
        scans(16'h0000, 3);
        n_vec++; if (key_count !== 3'(1 + 2 * REP)) begin $display("FAIL repeat_release: got %0d want %0d", key_count, 1 + 2 * REP); n_err++; end
        for (int j = 0; j < 1 + 2 * REP; j++) begin
            n_vec++; if (key_code !== 4'd5) begin $display("FAIL repeat_head[%0d]: got %0d want 5", j, key_code); n_err++; end
            pop1();
        end
        n_vec++; if (key_count !== 3'd0) begin $display("FAIL repeat_empty: got %0d want 0", key_count); n_err++; end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_overflow();
        test_reset_mid();
        test_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
